bank_cmd_scheduler: RTL and testbench
=====================================

Name: bank_cmd_scheduler

Overview:
- Rank-level command scheduler above the per-bank controllers. Each bank controller owns a per-bank timing counter covering tRCD/tRTP/tWR/tRP.
- Round-robin arbitration of bank command requests onto the single DRAM command bus.
- Enforces inter-bank timing: tRRD, tCCD, tWTR, optional tFAW.
- Sequences all-bank refresh: drain, REF issue, tRFC wait.

Parameters:
- NUM_BANKS, 8, number of bank-level requesters.
- BA_BITS, 3, bank address width; clog2(NUM_BANKS).
- CYCLE_TRRD, 4, ACT-to-ACT, different banks.
- CYCLE_TCCD, 4, column-to-column.
- CYCLE_TWTR, 12, WR-issue-to-RD-issue; includes write latency and burst.
- CYCLE_TRFC, 26, REF-to-any-command.
- CYCLE_TFAW, 20, four-activate window.
- All timing values are 1..31; counters are 5 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_BANKS  bank i requests a command; held until granted
- req_cmd  in  3*NUM_BANKS  per-bank command code (cmd_t), slice i
- bank_idle  in  NUM_BANKS  bank precharged and its own tRP expired
- refresh_req  in  1  refresh due; level, held until refresh_done
- cmd_stall  in  1  command bus unavailable this cycle
- grant  out  NUM_BANKS  one-hot grant pulse
- cmd_valid  out  1  command issued this cycle
- cmd_type  out  3  issued cmd_t
- cmd_bank  out  BA_BITS  issued bank
- refresh_done  out  1  one-cycle pulse at end of tRFC

Behaviour:
- Reset (rst high at posedge): all outputs 0; state S_NORMAL; rr_ptr=0; all timing counters 0; FAW history cleared. Reset mid-refresh returns to S_NORMAL and drops the pending refresh.
- cmd_t encoding: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5. Any other code is never eligible.
- Latency:
  - Eligibility and arbitration are evaluated combinationally in cycle N.
  - grant, cmd_valid, cmd_type and cmd_bank are registered and appear in cycle N+1.
  - At most one command is issued per cycle.
- Handshake:
  - A requester deasserts req_valid or changes req_cmd only in the cycle its grant is high.
  - A bank whose grant is high is masked from arbitration in that cycle, so the same request cannot be double-granted.
- Eligibility in S_NORMAL:
  - ACT: trrd_cnt==0, and fewer than 4 ACTs in the FAW window (feature only).
  - RD: tccd_cnt==0 and twtr_cnt==0.
  - WR: tccd_cnt==0.
  - PRE: always.
  - REF from a bank: never.
- cmd_stall=1: no grant in that cycle; counters keep decrementing.
- Round-robin:
  - The search starts at rr_ptr and wraps past NUM_BANKS-1 to 0.
  - After a grant to bank k, rr_ptr=(k+1) mod NUM_BANKS.
  - rr_ptr is unchanged when there is no grant.
- Counters:
  - On issue, load value-1: ACT loads trrd_cnt; RD/WR load tccd_cnt; WR loads twtr_cnt.
  - Otherwise each counter decrements and saturates at 0.
  - Loads and decrements happen in the cycle the command is selected (cycle N).
- FSM:
  - S_NORMAL -> S_DRAIN when refresh_req=1.
  - S_DRAIN: ACT is ineligible; RD/WR/PRE follow normal rules. -> S_REF when bank_idle is all ones and cmd_stall=0.
  - S_REF: issue one REF next cycle (cmd_type=REF, cmd_bank=0, grant=0); load rfc_cnt=CYCLE_TRFC-1; -> S_RFC.
  - S_RFC: no grants; rfc_cnt decrements. When rfc_cnt==0: pulse refresh_done, -> S_NORMAL.
- Simultaneous events: refresh_req rising in the same cycle as an ACT grant. The ACT still issues; S_DRAIN starts the next cycle.

Optional Feature:
- Macro: FAW_CHECK_EN.
- Defined:
  - A CYCLE_TFAW-bit shift register records ACT issues; it shifts every cycle.
  - ACT is eligible only when its popcount is below 4.
- Undefined: the shift register is absent and ACT is limited by tRRD only.

Decomposition:
- Shared package (usertype): cmd_t enum, sched_state_t (S_NORMAL, S_DRAIN, S_REF, S_RFC), and the CYCLE_* timing defaults.
- Sub-module rr_arbiter:
  - Inputs: eligible vector and pointer.
  - Output: one-hot winner, combinational.
  - Parameterised by NUM_BANKS.

Test Plan:
- Two banks request ACT at cycle 0. Bank 0 granted at cycle 1, bank 1 granted at cycle 5 (tRRD=4).
- Bank 3 WR then bank 5 RD requested together. WR issues at cycle 1; RD issues no earlier than 12 cycles after the WR selection (tWTR).
- FAW_CHECK_EN defined, 5 banks request ACT. Grants at cycles 1, 5, 9, 13; the 5th waits until cycle 21, at the window edge.
- All 8 banks request continuously, starting with rr_ptr=6. Grant order is 6, 7, 0, 1, ...; no bank is granted twice in 8 grants.
- refresh_req with bank 2 open:
  - ACT requests are held off; bank 2 PRE is granted.
  - bank_idle goes all ones, then REF is issued.
  - refresh_done pulses 26 cycles later; ACT grants resume.
- rst asserted during S_RFC. All outputs are 0 next cycle, state is S_NORMAL, and no refresh_done pulse.

Source files
------------

// File: rtl/bank_cmd_scheduler_pkg.sv
// Shared types and timing defaults for the rank-level bank command scheduler.
package bank_cmd_scheduler_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    S_NORMAL,
    S_DRAIN,
    S_REF,
    S_RFC
  } sched_state_t;

  localparam int unsigned CNT_W    = 5;
  localparam int unsigned DEF_TRRD = 4;
  localparam int unsigned DEF_TCCD = 4;
  localparam int unsigned DEF_TWTR = 12;
  localparam int unsigned DEF_TRFC = 26;
  localparam int unsigned DEF_TFAW = 20;

  // Codes 6 and 7, NOP and a bank-sourced REF are never eligible.
  function automatic logic cmd_allowed(cmd_t c, logic act_ok, logic rd_ok, logic wr_ok);
    case (c)
      CMD_ACT: return act_ok;
      CMD_RD:  return rd_ok;
      CMD_WR:  return wr_ok;
      CMD_PRE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bank_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after i_ptr wins.
module rr_arbiter #(
  parameter int NUM_BANKS = 8,
  localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic [NUM_BANKS-1:0] i_eligible,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [NUM_BANKS-1:0] o_winner
);

  logic             w_found;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int off = 0; off < NUM_BANKS; off++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(off);
      if (w_sum >= (PTR_W+1)'(NUM_BANKS)) w_sum = w_sum - (PTR_W+1)'(NUM_BANKS);
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && i_eligible[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Rank-level command scheduler: round-robin bank arbitration, inter-bank timing, refresh sequencing.
// Optional four-activate window enforcement is compiled in with `define FAW_CHECK_EN.
module bank_cmd_scheduler
  import bank_cmd_scheduler_pkg::*;
#(
  parameter int NUM_BANKS  = 8,
  parameter int BA_BITS    = 3,
  parameter int CYCLE_TRRD = DEF_TRRD,
  parameter int CYCLE_TCCD = DEF_TCCD,
  parameter int CYCLE_TWTR = DEF_TWTR,
`ifdef FAW_CHECK_EN
  parameter int CYCLE_TFAW = DEF_TFAW,
`endif
  parameter int CYCLE_TRFC = DEF_TRFC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BANKS-1:0]   req_valid,
  input  logic [3*NUM_BANKS-1:0] req_cmd,
  input  logic [NUM_BANKS-1:0]   bank_idle,
  input  logic                   refresh_req,
  input  logic                   cmd_stall,
  output logic [NUM_BANKS-1:0]   grant,
  output logic                   cmd_valid,
  output logic [2:0]             cmd_type,
  output logic [BA_BITS-1:0]     cmd_bank,
  output logic                   refresh_done
);

  sched_state_t         r_state;
  logic [BA_BITS-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]     r_trrd_cnt, r_tccd_cnt, r_twtr_cnt, r_rfc_cnt;
  logic [NUM_BANKS-1:0] r_grant;
  logic                 r_cmd_valid, r_refresh_done;
  cmd_t                 r_cmd_type;
  logic [BA_BITS-1:0]   r_cmd_bank;

  cmd_t                 w_cmd [NUM_BANKS];
  logic [NUM_BANKS-1:0] w_elig, w_winner;
  logic                 w_arb_en, w_act_ok, w_rd_ok, w_wr_ok, w_faw_ok, w_issue;
  logic [BA_BITS-1:0]   w_win_idx, w_next_ptr;
  cmd_t                 w_sel_cmd;

`ifdef FAW_CHECK_EN
  logic [CYCLE_TFAW-1:0] r_faw_hist;
  logic [CYCLE_TFAW-1:0] w_faw_win;

  // The oldest entry ages out at this edge, so it no longer counts against a new ACT.
  always_comb begin
    w_faw_win                 = r_faw_hist;
    w_faw_win[CYCLE_TFAW-1]   = 1'b0;
    w_faw_ok                  = $countones(w_faw_win) < 4;
  end

  always_ff @(posedge clk) begin
    if (rst) r_faw_hist <= '0;
    else     r_faw_hist <= (r_faw_hist << 1) | CYCLE_TFAW'(w_issue && w_sel_cmd == CMD_ACT);
  end
`else
  assign w_faw_ok = 1'b1;
`endif

  assign w_arb_en = !cmd_stall && (r_state == S_NORMAL || r_state == S_DRAIN);
  assign w_act_ok = (r_state == S_NORMAL) && (r_trrd_cnt == '0) && w_faw_ok;
  assign w_rd_ok  = (r_tccd_cnt == '0) && (r_twtr_cnt == '0);
  assign w_wr_ok  = (r_tccd_cnt == '0);

  // A bank whose grant is showing is masked so its still-asserted request is not granted twice.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_elig
    assign w_cmd[g]  = cmd_t'(req_cmd[3*g +: 3]);
    assign w_elig[g] = req_valid[g] && !r_grant[g] && w_arb_en &&
                       cmd_allowed(w_cmd[g], w_act_ok, w_rd_ok, w_wr_ok);
  end

  rr_arbiter #(.NUM_BANKS(NUM_BANKS)) u_arb (
    .i_eligible (w_elig),
    .i_ptr      (r_rr_ptr),
    .o_winner   (w_winner)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (w_winner[i]) w_win_idx = BA_BITS'(i);
    end
  end

  assign w_issue    = |w_winner;
  assign w_sel_cmd  = w_cmd[w_win_idx];
  assign w_next_ptr = (w_win_idx == BA_BITS'(NUM_BANKS-1)) ? '0 : w_win_idx + 1'b1;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_NORMAL;
      r_rr_ptr       <= '0;
      r_trrd_cnt     <= '0;
      r_tccd_cnt     <= '0;
      r_twtr_cnt     <= '0;
      r_rfc_cnt      <= '0;
      r_grant        <= '0;
      r_cmd_valid    <= 1'b0;
      r_cmd_type     <= CMD_NOP;
      r_cmd_bank     <= '0;
      r_refresh_done <= 1'b0;
    end else begin
      if (w_issue && w_sel_cmd == CMD_ACT)         r_trrd_cnt <= CNT_W'(CYCLE_TRRD - 1);
      else if (r_trrd_cnt != '0)                   r_trrd_cnt <= r_trrd_cnt - 1'b1;
      if (w_issue && (w_sel_cmd == CMD_RD || w_sel_cmd == CMD_WR))
                                                   r_tccd_cnt <= CNT_W'(CYCLE_TCCD - 1);
      else if (r_tccd_cnt != '0)                   r_tccd_cnt <= r_tccd_cnt - 1'b1;
      if (w_issue && w_sel_cmd == CMD_WR)          r_twtr_cnt <= CNT_W'(CYCLE_TWTR - 1);
      else if (r_twtr_cnt != '0)                   r_twtr_cnt <= r_twtr_cnt - 1'b1;

      r_grant        <= w_winner;
      r_cmd_valid    <= w_issue;
      r_cmd_type     <= w_issue ? w_sel_cmd : CMD_NOP;
      r_cmd_bank     <= w_issue ? w_win_idx : '0;
      r_refresh_done <= 1'b0;
      if (w_issue) r_rr_ptr <= w_next_ptr;

      case (r_state)
        // refresh_req may still read high in the cycle refresh_done is showing.
        S_NORMAL: if (refresh_req && !r_refresh_done) r_state <= S_DRAIN;
        S_DRAIN:  if (&bank_idle && !cmd_stall) r_state <= S_REF;
        S_REF: begin
          if (!cmd_stall) begin
            r_cmd_valid <= 1'b1;
            r_cmd_type  <= CMD_REF;
            r_cmd_bank  <= '0;
            r_rfc_cnt   <= CNT_W'(CYCLE_TRFC - 1);
            r_state     <= S_RFC;
          end
        end
        S_RFC: begin
          if (r_rfc_cnt == '0) begin
            r_refresh_done <= 1'b1;
            r_state        <= S_NORMAL;
          end else begin
            r_rfc_cnt <= r_rfc_cnt - 1'b1;
          end
        end
        default: r_state <= S_NORMAL;
      endcase
    end
  end

  assign grant        = r_grant;
  assign cmd_valid    = r_cmd_valid;
  assign cmd_type     = r_cmd_type;
  assign cmd_bank     = r_cmd_bank;
  assign refresh_done = r_refresh_done;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Scoreboard bench for bank_cmd_scheduler: directed stimulus pushes expected issues, a monitor pops and compares.
module tb_bank_cmd_scheduler;
  import bank_cmd_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  req_valid = '0;
  logic [23:0] req_cmd = '0;
  logic [7:0]  bank_idle = 8'hFF;
  logic        refresh_req = 1'b0;
  logic        cmd_stall = 1'b0;
  logic [7:0]  grant;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [2:0]  cmd_bank;
  logic        refresh_done;

  logic [7:0]  hold = '0;
  int          cyc = 0;
  int          n_vectors = 0;
  int          n_miscompares = 0;

  typedef struct {
    int         cyc;
    logic [2:0] typ;
    logic [2:0] bank;
    logic       done;
  } exp_t;
  exp_t exp_q[$];

  bank_cmd_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .bank_idle    (bank_idle),
    .refresh_req  (refresh_req),
    .cmd_stall    (cmd_stall),
    .grant        (grant),
    .cmd_valid    (cmd_valid),
    .cmd_type     (cmd_type),
    .cmd_bank     (cmd_bank),
    .refresh_done (refresh_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_cmd(input int c, input cmd_t t, input int b);
    exp_t e;
    e.cyc = c; e.typ = t; e.bank = 3'(b); e.done = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic expect_done(input int c);
    exp_t e;
    e.cyc = c; e.typ = CMD_NOP; e.bank = '0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int b, input cmd_t c);
    req_cmd[3*b +: 3] = c;
    req_valid[b]      = 1'b1;
  endtask

  // Advance one cycle; requesters drop a request in the cycle its grant is showing.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (grant[i] && !hold[i]) req_valid[i] = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic compare_item(input logic is_done);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vectors++;
      n_miscompares++;
      $display("FAIL unexpected_output at cycle %0d: got valid=%0b type=%0d bank=%0d done=%0b, expected nothing",
               cyc, cmd_valid, cmd_type, cmd_bank, refresh_done);
    end else begin
      e = exp_q.pop_front();
      check("output_kind_done", 32'(is_done), 32'(e.done));
      check("issue_cycle", cyc, e.cyc);
      if (!is_done) begin
        check("cmd_type_bank", {cmd_type, cmd_bank}, {e.typ, e.bank});
        check("grant_vec", grant, (e.typ == CMD_REF) ? 32'd0 : (32'd1 << e.bank));
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmd_valid)    compare_item(1'b0);
    if (refresh_done) compare_item(1'b1);
    if (!cmd_valid && grant != '0) check("grant_without_cmd", grant, 0);
  end

  initial begin
    int b;

    ticks(3);
    check("reset_outputs", {grant, cmd_valid, cmd_type, cmd_bank, refresh_done}, 0);
    rst = 1'b0;
    tick();

    // Two ACTs: second one held off by tRRD.
    b = cyc;
    set_req(0, CMD_ACT); set_req(1, CMD_ACT);
    expect_cmd(b+1, CMD_ACT, 0);
    expect_cmd(b+5, CMD_ACT, 1);
    ticks(8);

    // WR on bank 3 then RD on bank 5: RD waits out tWTR.
    b = cyc;
    set_req(3, CMD_WR); set_req(5, CMD_RD);
    expect_cmd(b+1,  CMD_WR, 3);
    expect_cmd(b+13, CMD_RD, 5);
    ticks(16);

    // Five ACTs from rr_ptr=6; fifth limited by the four-activate window when enabled.
    b = cyc;
    set_req(6, CMD_ACT); set_req(7, CMD_ACT); set_req(0, CMD_ACT);
    set_req(1, CMD_ACT); set_req(2, CMD_ACT);
    expect_cmd(b+1,  CMD_ACT, 6);
    expect_cmd(b+5,  CMD_ACT, 7);
    expect_cmd(b+9,  CMD_ACT, 0);
    expect_cmd(b+13, CMD_ACT, 1);
`ifdef FAW_CHECK_EN
    expect_cmd(b+21, CMD_ACT, 2);
`else
    expect_cmd(b+17, CMD_ACT, 2);
`endif
    ticks(26);

    // Park rr_ptr at 6, then all eight banks request PRE continuously.
    b = cyc;
    set_req(5, CMD_PRE);
    expect_cmd(b+1, CMD_PRE, 5);
    tick();
    b = cyc;
    hold = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      set_req(i, CMD_PRE);
      expect_cmd(b+1+i, CMD_PRE, (6+i) % 8);
    end
    ticks(8);
    hold = '0;
    req_valid = '0;
    ticks(3);

    // Refresh with bank 2 open: PRE goes out, ACT held through drain/REF/tRFC.
    b = cyc;
    bank_idle = 8'b1111_1011;
    refresh_req = 1'b1;
    set_req(2, CMD_PRE); set_req(4, CMD_ACT);
    expect_cmd(b+1, CMD_PRE, 2);
    expect_cmd(b+3, CMD_REF, 0);
    expect_done(b+29);
    expect_cmd(b+30, CMD_ACT, 4);
    tick();
    bank_idle = 8'hFF;
    for (int k = 0; k < 60 && !refresh_done; k++) tick();
    refresh_req = 1'b0;
    ticks(4);

    // Bus stall delays a PRE until the stall lifts.
    b = cyc;
    cmd_stall = 1'b1;
    set_req(1, CMD_PRE);
    ticks(3);
    cmd_stall = 1'b0;
    expect_cmd(b+4, CMD_PRE, 1);
    ticks(4);

    // Reset in the middle of tRFC: no refresh_done afterwards, pointer back to 0.
    b = cyc;
    refresh_req = 1'b1;
    expect_cmd(b+3, CMD_REF, 0);
    ticks(6);
    rst = 1'b1;
    refresh_req = 1'b0;
    tick();
    check("reset_mid_refresh", {grant, cmd_valid, cmd_type, cmd_bank, refresh_done}, 0);
    rst = 1'b0;
    ticks(30);
    b = cyc;
    set_req(7, CMD_ACT); set_req(0, CMD_ACT);
    expect_cmd(b+1, CMD_ACT, 0);
    expect_cmd(b+5, CMD_ACT, 7);
    ticks(8);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
